// File: rtl/sd_dat_pkg.sv
// Constants shared by the DAT data path: word width, FIFO depth and block size.
package sd_dat_pkg;
  localparam int DAT_WORD_W      = 32;
  localparam int DAT_FIFO_DEPTH  = 16;
  localparam int DAT_BLOCK_WORDS = 128;
endpackage

// File: rtl/dat_fifo_mem.sv
// Register-array storage for dat_fifo: one write port, one registered read port.
module dat_fifo_mem
  import sd_dat_pkg::*;
#(
  parameter int WIDTH = DAT_WORD_W,
  parameter int DEPTH = DAT_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Array has no reset so it maps cleanly onto a RAM macro later.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/dat_fifo.sv
// Single-clock word FIFO between host data path and dat_phys, with occupancy,
// almost-full threshold, synchronous flush and sticky overflow/underflow.
module dat_fifo
  import sd_dat_pkg::*;
#(
  parameter int WIDTH    = DAT_WORD_W,
  parameter int DEPTH    = DAT_FIFO_DEPTH,
  parameter int AF_LEVEL = 12
) (
  input  logic                     sd_clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     write_enable,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         data_out,
  output logic                     status,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wp, rp;
  logic          push, pop;

  assign status      = (count != '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_LEVEL));

  // A pop frees a slot in the same edge, so a full FIFO still takes a push.
  assign pop  = read_enable & status & ~flush;
  assign push = write_enable & (~full | pop) & ~flush;

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (write_enable && !push) overflow  <= 1'b1;
      if (read_enable  && !pop)  underflow <= 1'b1;
    end
  end

  dat_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (sd_clock),
    .rst_n   (reset),
    .wr_en   (push),
    .wr_addr (wp),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_addr (rp),
    .rd_data (data_out)
  );
endmodule

// File: tb/tb_dat_fifo.sv
// Directed self-checking bench for dat_fifo (WIDTH 32, DEPTH 16, AF_LEVEL 12).
module tb_dat_fifo;
  logic        sd_clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] data_in = '0;
  logic        read_enable = 1'b0;
  logic [31:0] data_out;
  logic        status, full, almost_full, overflow, underflow;
  logic [4:0]  count;

  int tests = 0;
  int fails = 0;

  dat_fifo #(.WIDTH(32), .DEPTH(16), .AF_LEVEL(12)) dut (
    .sd_clock     (sd_clock),
    .reset        (reset),
    .flush        (flush),
    .write_enable (write_enable),
    .data_in      (data_in),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .status       (status),
    .full         (full),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 sd_clock = ~sd_clock;

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cycle(input logic we, input logic re, input logic [31:0] d);
    write_enable = we; read_enable = re; data_in = d;
    @(negedge sd_clock);
    write_enable = 1'b0; read_enable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; flush = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    @(negedge sd_clock); @(negedge sd_clock);
    reset = 1'b1;
    @(negedge sd_clock);
  endtask

  function automatic logic [31:0] fill_word(input int i);
    return (i < 16) ? 32'(i) * 32'h11111111 : 32'h10101010;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    #2;
    tests++;
    if ({data_out, count, status, full, almost_full, overflow, underflow} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got dout=%h cnt=%0d st=%b f=%b af=%b ov=%b un=%b, want all 0",
               data_out, count, status, full, almost_full, overflow, underflow);
    end
    @(negedge sd_clock);
    reset = 1'b1;
    @(negedge sd_clock);
    cycle(1'b0, 1'b1, '0);
    tests++;
    if (underflow !== 1'b1 || data_out !== 32'h0 || count !== 5'd0) begin
      fails++;
      $display("FAIL idle_pop: got un=%b dout=%h cnt=%0d, want un=1 dout=0 cnt=0",
               underflow, data_out, count);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, fill_word(i));
      tests++;
      if (count !== 5'(i) || almost_full !== (i >= 12) || full !== (i == 16)) begin
        fails++;
        $display("FAIL fill_%0d: got cnt=%0d af=%b f=%b, want cnt=%0d af=%b f=%b",
                 i, count, almost_full, full, i, (i >= 12), (i == 16));
      end
    end
    cycle(1'b1, 1'b0, 32'hDEADBEEF);
    tests++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      fails++;
      $display("FAIL overflow_push: got ov=%b cnt=%0d, want ov=1 cnt=16", overflow, count);
    end
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, '0);
      tests++;
      if (data_out !== fill_word(i)) begin
        fails++;
        $display("FAIL drain_%0d: got %h, want %h", i, data_out, fill_word(i));
      end
    end
    tests++;
    if (status !== 1'b0 || count !== 5'd0) begin
      fails++;
      $display("FAIL drained_status: got st=%b cnt=%0d, want st=0 cnt=0", status, count);
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 32'h100 + 32'(i));
    cycle(1'b1, 1'b1, 32'hCAFEF00D);
    tests++;
    if (count !== 5'd16 || full !== 1'b1 || data_out !== 32'h100 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_rw: got cnt=%0d f=%b dout=%h ov=%b, want cnt=16 f=1 dout=00000100 ov=0",
               count, full, data_out, overflow);
    end
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 1'b1, '0);
      tests++;
      if (data_out !== 32'h100 + 32'(i)) begin
        fails++;
        $display("FAIL full_rw_drain_%0d: got %h, want %h", i, data_out, 32'h100 + 32'(i));
      end
    end
    cycle(1'b0, 1'b1, '0);
    tests++;
    if (data_out !== 32'hCAFEF00D || count !== 5'd0) begin
      fails++;
      $display("FAIL full_rw_last: got dout=%h cnt=%0d, want dout=cafef00d cnt=0", data_out, count);
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    cycle(1'b1, 1'b1, 32'hA5A5A5A5);
    tests++;
    if (count !== 5'd1 || underflow !== 1'b1 || data_out !== 32'h0) begin
      fails++;
      $display("FAIL empty_rw: got cnt=%0d un=%b dout=%h, want cnt=1 un=1 dout=0",
               count, underflow, data_out);
    end
    cycle(1'b0, 1'b1, '0);
    tests++;
    if (data_out !== 32'hA5A5A5A5 || count !== 5'd0) begin
      fails++;
      $display("FAIL empty_rw_pop: got dout=%h cnt=%0d, want dout=a5a5a5a5 cnt=0", data_out, count);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] q[$];
    logic [31:0] exp;
    int n = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h2000 + 32'(n)); q.push_back(32'h2000 + 32'(n)); n++;
    end
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        cycle(1'b1, 1'b0, 32'h2000 + 32'(n)); q.push_back(32'h2000 + 32'(n)); n++;
      end else begin
        cycle(1'b0, 1'b1, '0);
        exp = q.pop_front();
        tests++;
        if (data_out !== exp) begin
          fails++;
          $display("FAIL wrap_pop_%0d: got %h, want %h", i, data_out, exp);
        end
      end
      tests++;
      if (count !== 5'(q.size()) || count > 5'd4) begin
        fails++;
        $display("FAIL wrap_count_%0d: got %0d, want %0d", i, count, q.size());
      end
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 32'h300 + 32'(i));
    cycle(1'b1, 1'b0, 32'hFFFF0000);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, '0);
    tests++;
    if (count !== 5'd9 || overflow !== 1'b1 || data_out !== 32'h306) begin
      fails++;
      $display("FAIL flush_setup: got cnt=%0d ov=%b dout=%h, want cnt=9 ov=1 dout=00000306",
               count, overflow, data_out);
    end
    flush = 1'b1;
    cycle(1'b1, 1'b1, 32'h77777777);
    flush = 1'b0;
    tests++;
    if (count !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0 || status !== 1'b0 ||
        almost_full !== 1'b0 || data_out !== 32'h306) begin
      fails++;
      $display("FAIL flush: got cnt=%0d ov=%b un=%b st=%b af=%b dout=%h, want cnt=0 flags 0 dout=00000306",
               count, overflow, underflow, status, almost_full, data_out);
    end
    cycle(1'b1, 1'b0, 32'h88888888);
    cycle(1'b0, 1'b1, '0);
    tests++;
    if (data_out !== 32'h88888888 || count !== 5'd0 || underflow !== 1'b0) begin
      fails++;
      $display("FAIL post_flush: got dout=%h cnt=%0d un=%b, want dout=88888888 cnt=0 un=0",
               data_out, count, underflow);
    end
    write_enable = 1'b1; read_enable = 1'b1; data_in = 32'h99999999;
    @(negedge sd_clock); @(negedge sd_clock); @(negedge sd_clock);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({data_out, count, status, full, almost_full, overflow, underflow} !== '0) begin
      fails++;
      $display("FAIL async_reset: got dout=%h cnt=%0d st=%b ov=%b un=%b, want all 0",
               data_out, count, status, overflow, underflow);
    end
    write_enable = 1'b0; read_enable = 1'b0;
    @(negedge sd_clock);
    reset = 1'b1;
    @(negedge sd_clock);
    tests++;
    if (count !== 5'd0 || status !== 1'b0 || data_out !== 32'h0) begin
      fails++;
      $display("FAIL after_reset: got cnt=%0d st=%b dout=%h, want 0", count, status, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dat_fifo.md
# dat_fifo

Word buffer between the host-side data path and the DAT physical layer (`dat_phys`). On writes the host fills it and `dat_phys` drains it through `read_enable`/`dataFROMFIFO`/`status`. On reads `dat_phys` fills it through `write_enable`/`dataToFIFO` and the host drains it. It is a single-clock synchronous FIFO with occupancy count, almost-full threshold, synchronous flush and sticky overflow/underflow flags.

## Interface

Parameters:
- `WIDTH`, 32, data word width; matches the `dat_phys` FIFO buses.
- `DEPTH`, 16, number of words; must be a power of two, minimum 4.
- `AF_LEVEL`, 12, `almost_full` asserts when count ≥ `AF_LEVEL`; range 1..`DEPTH`.

Ports:
- `sd_clock`, input, 1: the single clock; all logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous clear of contents and flags; overrides reads and writes that cycle.
- `write_enable`, input, 1: push request.
- `data_in`, input, `WIDTH`: word to push.
- `read_enable`, input, 1: pop request.
- `data_out`, output, `WIDTH`: last popped word; connects to `dataFROMFIFO`.
- `status`, output, 1: high when count > 0, meaning a read is permitted.
- `full`, output, 1: high when count == `DEPTH`.
- `almost_full`, output, 1: high when count ≥ `AF_LEVEL`.
- `count`, output, log2(`DEPTH`)+1: current occupancy, 0..`DEPTH`.
- `overflow`, output, 1: sticky; set by a rejected push.
- `underflow`, output, 1: sticky; set by a rejected pop.

## Operation

- Storage is `DEPTH` words addressed by a write pointer `wp` and a read pointer `rp`, each log2(`DEPTH`) bits.
- Both pointers wrap modulo `DEPTH` with natural binary rollover.
- `count` is a separate register, not derived from the pointers.
- A push is accepted when `write_enable` is high and either:
  - `full` is low, or
  - a pop is accepted in the same cycle.
- An accepted push writes `data_in` at `wp` and increments `wp`.
- A push that is not accepted leaves storage unchanged and sets `overflow`.
- A pop is accepted when `read_enable` is high and `status` is high, evaluated on pre-edge state. An accepted pop registers mem[`rp`] into `data_out` and increments `rp`.
- A pop that is not accepted leaves `data_out` unchanged and sets `underflow`.
- Simultaneous push and pop:
  - When empty: the push is accepted, the pop is rejected, and `underflow` is set.
  - When full: both are accepted and `count` is unchanged.
  - Otherwise: both are accepted and `count` is unchanged.
- Count update: +1 for a push only, −1 for a pop only, no change for both or neither.
- `flush` high does all of the following at the edge:
  - `wp`, `rp` and `count` go to 0.
  - `overflow` and `underflow` clear.
  - `data_out` is held.
  - Requests that cycle are ignored and do not set flags.
- Flags clear only on `reset` or `flush`.
- `status`, `full` and `almost_full` are combinational decodes of the `count` register and have no path from the request inputs.

## Timing

- Reset values (asynchronous, `reset` low):
  - `wp`, `rp`, `count` = 0.
  - `data_out` = 0.
  - `status` = 0, `full` = 0, `almost_full` = 0.
  - `overflow` = 0, `underflow` = 0.
- A reset asserted mid-operation discards all contents immediately. Stored memory words need not be cleared.
- Read latency: `data_out` holds the popped word from the edge after `read_enable` is sampled high with `status` high.
- `data_out` holds that word until the next accepted pop.
- Write-to-read latency: a word pushed at edge N raises `status` after edge N. It can be popped at edge N+1 and appears on `data_out` after edge N+1. There is no bypass through an empty FIFO.
- Throughput: one push and one pop per cycle, sustained.
- Flag updates are visible in the cycle after the triggering edge.

## Structure

- Shared package `sd_dat_pkg`:
  - `DAT_WORD_W` = 32.
  - `DAT_FIFO_DEPTH` = 16.
  - `DAT_BLOCK_WORDS` = 128, i.e. a 512-byte block.
- `dat_phys` uses these same constants.
- Sub-module `dat_fifo_mem`: a simple dual-port register array with one write port and one registered read port, so it can later be swapped for a RAM macro.
- Pointer, count and flag control stays in `dat_fifo`.

## Test plan

- Reset then idle: all outputs are 0; `read_enable` pulse → `underflow`=1, `data_out` stays 0, `count` stays 0.
- Push 0x11111111..0x10101010 (16 words), then push 0xDEADBEEF:
  - `almost_full` rises after the 12th push.
  - `full`=1 after the 16th push.
  - The 17th push sets `overflow` and `count` stays 16.
  - 16 pops return 0x11111111..0x10101010 in order, then `status`=0.
- Full FIFO with simultaneous push 0xCAFEF00D and pop: both accepted, `count` stays 16, `data_out` = oldest word, and 0xCAFEF00D is read out 16 pops later.
- Empty FIFO with simultaneous push 0xA5A5A5A5 and pop: `count`=1, `underflow`=1, `data_out` unchanged; the next pop returns 0xA5A5A5A5.
- Wrap-around: run 40 pushes and pops interleaved at an occupancy of 3; data order is preserved across pointer wrap and `count` never exceeds 4.
- `flush` with `count`=9 and `overflow`=1, together with push and pop requests: `count`=0, flags clear, `data_out` held, requests ignored. Repeat with an async `reset` pulse mid-burst: everything returns to reset values.
